// File: rtl/uart_cmd_pkg.sv
// Shared state enumeration, protocol constants and counter sizing for uart_cmd_decoder.
// Defining CMD_ACK_EN adds the two acknowledgement states.
package uart_cmd_pkg;

    localparam logic [7:0] CMD_LED     = 8'hFF;
    localparam logic [7:0] CMD_WR_BASE = 8'hE0;
    localparam logic [7:0] LED_PAYLOAD = 8'h01;

`ifdef CMD_ACK_EN
    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        ACK_SEND,
        ACK_WAIT
    } state_t;
`else
    typedef enum logic {
        IDLE,
        PAYLOAD
    } state_t;
`endif

    // Counter only needs to hold 0..cycles-1.
    function automatic int cnt_width(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/cmd_timeout_cnt.sv
// Clearable, enable-gated cycle counter; expired is high while enabled and the
// count sits at TIMEOUT_CYC-1.
module cmd_timeout_cnt
    import uart_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYC = 100_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int            CW   = cnt_width(TIMEOUT_CYC);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (en && (cnt_reg != LAST)) begin
            cnt_reg <= cnt_reg + CW'(1);
        end
    end

    assign expired = en && (cnt_reg == LAST);

endmodule

// File: rtl/uart_cmd_decoder.sv
// Two-byte UART command decoder: LED toggle or channel-register write with payload timeout.
// Optional CMD_ACK_EN echoes each accepted header through tx_start/tx_data.
module uart_cmd_decoder
    import uart_cmd_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int TIMEOUT_CYC = 100_000_000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          rx_data,
    input  logic                rx_done,
    input  logic                tx_done,
    output logic                led,
    output logic [NUM_CH*8-1:0] ch_data,
    output logic [NUM_CH-1:0]   ch_update,
    output logic                frame_err,
    output logic [7:0]          err_cnt,
    output logic                busy,
    output logic                tx_start,
    output logic [7:0]          tx_data
);

    state_t     state_reg;
    state_t     state_next;
    logic       cmd_led_reg;
    logic [3:0] ch_idx_reg;
    logic       led_reg;
    logic       frame_err_reg;
    logic [7:0] err_cnt_reg;

    logic hdr_valid;
    logic hdr_load;
    logic wr_en;
    logic led_flip;
    logic err_event;
    logic cnt_clr;
    logic tmo_expired;
    logic ack_load;

    // Out-of-range channel headers fall through here and are silently ignored.
    assign hdr_valid = (rx_data == CMD_LED) ||
                       ((rx_data[7:4] == CMD_WR_BASE[7:4]) &&
                        ({1'b0, rx_data[3:0]} < 5'(NUM_CH)));

    cmd_timeout_cnt #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clr     (cnt_clr),
        .en      (state_reg == PAYLOAD),
        .expired (tmo_expired)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        hdr_load   = 1'b0;
        wr_en      = 1'b0;
        led_flip   = 1'b0;
        err_event  = 1'b0;
        cnt_clr    = 1'b0;
        ack_load   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (rx_done && hdr_valid) begin
                    hdr_load   = 1'b1;
                    cnt_clr    = 1'b1;
                    state_next = PAYLOAD;
                end
            end
            PAYLOAD: begin
                // A byte on the expiry cycle still completes the frame.
                if (rx_done) begin
                    if (cmd_led_reg) begin
                        if (rx_data == LED_PAYLOAD) begin
                            led_flip = 1'b1;
                        end else begin
                            err_event = 1'b1;
                        end
                    end else begin
                        wr_en = 1'b1;
                    end
`ifdef CMD_ACK_EN
                    state_next = err_event ? IDLE : ACK_SEND;
`else
                    state_next = IDLE;
`endif
                end else if (tmo_expired) begin
                    err_event  = 1'b1;
                    state_next = IDLE;
                end
            end
`ifdef CMD_ACK_EN
            ACK_SEND: begin
                ack_load   = 1'b1;
                err_event  = rx_done;
                state_next = ACK_WAIT;
            end
            ACK_WAIT: begin
                err_event = rx_done;
                if (tx_done) begin
                    state_next = IDLE;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cmd_led_reg   <= 1'b0;
            ch_idx_reg    <= '0;
            led_reg       <= 1'b0;
            frame_err_reg <= 1'b0;
            err_cnt_reg   <= '0;
        end else begin
            if (hdr_load) begin
                cmd_led_reg <= (rx_data == CMD_LED);
                ch_idx_reg  <= rx_data[3:0];
            end
            if (led_flip) begin
                led_reg <= ~led_reg;
            end
            frame_err_reg <= err_event;
            if (err_event && (err_cnt_reg != 8'hFF)) begin
                err_cnt_reg <= err_cnt_reg + 8'd1;
            end
        end
    end

    // Channel register file, one byte and one update strobe per channel.
    logic [7:0] ch_reg  [NUM_CH];
    logic       upd_reg [NUM_CH];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            always_ff @(posedge clk) begin
                if (!reset) begin
                    ch_reg[gi]  <= '0;
                    upd_reg[gi] <= 1'b0;
                end else begin
                    upd_reg[gi] <= wr_en && (ch_idx_reg == 4'(gi));
                    if (wr_en && (ch_idx_reg == 4'(gi))) begin
                        ch_reg[gi] <= rx_data;
                    end
                end
            end
            assign ch_data[gi*8 +: 8] = ch_reg[gi];
            assign ch_update[gi]      = upd_reg[gi];
        end
    endgenerate

`ifdef CMD_ACK_EN
    logic [7:0] hdr_reg;
    logic       tx_start_reg;
    logic [7:0] tx_data_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            hdr_reg      <= '0;
            tx_start_reg <= 1'b0;
            tx_data_reg  <= '0;
        end else begin
            if (hdr_load) begin
                hdr_reg <= rx_data;
            end
            tx_start_reg <= ack_load;
            if (ack_load) begin
                tx_data_reg <= hdr_reg;
            end
        end
    end

    assign tx_start = tx_start_reg;
    assign tx_data  = tx_data_reg;
`else
    logic unused_tx_done;
    logic unused_ack_load;
    assign unused_tx_done  = tx_done;
    assign unused_ack_load = ack_load;
    assign tx_start        = 1'b0;
    assign tx_data         = 8'h00;
`endif

    assign led       = led_reg;
    assign frame_err = frame_err_reg;
    assign err_cnt   = err_cnt_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Self-checking bench for uart_cmd_decoder: frame-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized byte streams.
module tb_uart_cmd_decoder;

    localparam int NUM_CH      = 4;
    localparam int TIMEOUT_CYC = 20;

    logic                clk     = 1'b0;
    logic                reset   = 1'b0;
    logic [7:0]          rx_data = 8'h00;
    logic                rx_done = 1'b0;
    logic                tx_done = 1'b0;
    logic                led;
    logic [NUM_CH*8-1:0] ch_data;
    logic [NUM_CH-1:0]   ch_update;
    logic                frame_err;
    logic [7:0]          err_cnt;
    logic                busy;
    logic                tx_start;
    logic [7:0]          tx_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_cmd_decoder #(
        .NUM_CH      (NUM_CH),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .tx_done   (tx_done),
        .led       (led),
        .ch_data   (ch_data),
        .ch_update (ch_update),
        .frame_err (frame_err),
        .err_cnt   (err_cnt),
        .busy      (busy),
        .tx_start  (tx_start),
        .tx_data   (tx_data)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    logic [7:0]        m_ch [NUM_CH];
    logic [NUM_CH-1:0] m_upd = '0;
    logic              m_led = 1'b0;
    logic              m_err = 1'b0;
    logic              m_txs = 1'b0;
    logic [7:0]        m_cnt = 8'h00;
    logic [7:0]        m_txd = 8'h00;
    bit                pend   = 1'b0;
    bit                acking = 1'b0;
    logic [7:0]        pend_hdr = 8'h00;
    logic [7:0]        ack_hdr  = 8'h00;
    longint            hdr_cyc  = 0;
    longint            ack_from = 0;
    longint            cyc      = 0;
    int                ack_delay = 3;
    bit                ack_rand  = 1'b0;

    function automatic bit is_hdr(input logic [7:0] b);
        return (b == 8'hFF) || (int'(b) >= 224 && int'(b) < 224 + NUM_CH);
    endfunction

    function automatic logic [NUM_CH*8-1:0] pack_ch();
        logic [NUM_CH*8-1:0] v;
        v = '0;
        for (int k = 0; k < NUM_CH; k++) v[k*8 +: 8] = m_ch[k];
        return v;
    endfunction

    task automatic bump_err();
        m_err = 1'b1;
        if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
    endtask

    task automatic start_ack();
`ifdef CMD_ACK_EN
        acking   = 1'b1;
        ack_from = cyc;
        ack_hdr  = pend_hdr;
`endif
    endtask

    always @(posedge clk) begin
        m_upd = '0;
        m_err = 1'b0;
        m_txs = 1'b0;
        if (!reset) begin
            for (int k = 0; k < NUM_CH; k++) m_ch[k] = 8'h00;
            m_led  = 1'b0;
            m_cnt  = 8'h00;
            m_txd  = 8'h00;
            pend   = 1'b0;
            acking = 1'b0;
        end else if (pend) begin
            if (rx_done) begin
                pend = 1'b0;
                if (pend_hdr == 8'hFF) begin
                    if (rx_data == 8'h01) begin
                        m_led = ~m_led;
                        start_ack();
                    end else begin
                        bump_err();
                    end
                end else begin
                    m_ch[int'(pend_hdr) - 224]  = rx_data;
                    m_upd[int'(pend_hdr) - 224] = 1'b1;
                    start_ack();
                end
            end else if (cyc == hdr_cyc + TIMEOUT_CYC) begin
                pend = 1'b0;
                bump_err();
            end
        end else if (acking) begin
            if (rx_done) bump_err();
            if (cyc == ack_from + 1) begin
                m_txs = 1'b1;
                m_txd = ack_hdr;
            end else if (tx_done) begin
                acking = 1'b0;
            end
        end else if (rx_done && is_hdr(rx_data)) begin
            pend     = 1'b1;
            pend_hdr = rx_data;
            hdr_cyc  = cyc;
        end
        cyc++;
        #1;
        chk("led",       64'(led),       64'(m_led));
        chk("ch_data",   64'(ch_data),   64'(pack_ch()));
        chk("ch_update", 64'(ch_update), 64'(m_upd));
        chk("frame_err", 64'(frame_err), 64'(m_err));
        chk("err_cnt",   64'(err_cnt),   64'(m_cnt));
        chk("busy",      64'(busy),      64'(pend || acking));
        chk("tx_start",  64'(tx_start),  64'(m_txs));
        chk("tx_data",   64'(tx_data),   64'(m_txd));
    end

    // ---------------- stimulus ----------------
`ifdef CMD_ACK_EN
    initial forever begin
        @(negedge clk);
        if (tx_start) begin
            int d;
            d = ack_rand ? int'($urandom_range(1, 6)) : ack_delay;
            repeat (d) @(negedge clk);
            tx_done = 1'b1;
            @(negedge clk);
            tx_done = 1'b0;
        end
    end
`else
    initial forever begin
        @(negedge clk);
        tx_done = ($urandom_range(0, 5) == 0);
    end
`endif

    task automatic send(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        rx_data = 8'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle(2);
        reset = 1'b1;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog t=%0t got=running want=finished", $time);
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        logic [7:0] h;
        logic [7:0] p;
        int         k;
        int         g;
        bit         seen;

        @(negedge clk);
        idle(2);
        reset = 1'b1;
        idle(1);
        chk("lit_reset_err_cnt", 64'(err_cnt), 64'h0);
        chk("lit_reset_ch_data", 64'(ch_data), 64'h0);
        chk("lit_reset_busy",    64'(busy),    64'h0);

        send(8'hE2); send(8'h5A);
        chk("lit_wr_update", 64'(ch_update), 64'h4);
        chk("lit_wr_ch2",    64'(ch_data[23:16]), 64'h5A);
        chk("lit_wr_others", 64'(ch_data & 32'hFF00FFFF), 64'h0);
        idle(12);

        send(8'hFF); send(8'h01);
        chk("lit_led_on", 64'(led), 64'h1);
        idle(12);
        send(8'hFF); send(8'h01);
        chk("lit_led_off", 64'(led), 64'h0);
        idle(12);
        send(8'hFF); send(8'h02);
        chk("lit_led_bad_err",  64'(frame_err), 64'h1);
        chk("lit_led_bad_cnt",  64'(err_cnt),   64'h1);
        chk("lit_led_bad_led",  64'(led),       64'h0);
        idle(12);

        send(8'hE1); idle(25);
        chk("lit_tmo_cnt",  64'(err_cnt), 64'h2);
        chk("lit_tmo_idle", 64'(busy),    64'h0);
        send(8'h33);
        chk("lit_tmo_stray_ignored", 64'(busy), 64'h0);
        idle(3);
        send(8'hE1); idle(TIMEOUT_CYC - 1); send(8'h77);
        chk("lit_tmo_edge_ch1", 64'(ch_data[15:8]), 64'h77);
        chk("lit_tmo_edge_cnt", 64'(err_cnt),       64'h2);
        idle(12);

        do_reset();
        send(8'hE5); send(8'hE0); send(8'h11);
        chk("lit_badch_ch0", 64'(ch_data[7:0]), 64'h11);
        chk("lit_badch_cnt", 64'(err_cnt),      64'h0);
        idle(12);
        send(8'hE0); do_reset();
        chk("lit_midreset_ch",   64'(ch_data),   64'h0);
        chk("lit_midreset_busy", 64'(busy),      64'h0);
        chk("lit_midreset_err",  64'(frame_err), 64'h0);
        chk("lit_midreset_led",  64'(led),       64'h0);

`ifdef CMD_ACK_EN
        ack_delay = 8;
        send(8'hE3); send(8'h7F);
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            if (tx_start) seen = 1'b1;
            else @(negedge clk);
        end
        chk("lit_ack_tx_start", 64'(seen),    64'h1);
        chk("lit_ack_tx_data",  64'(tx_data), 64'hE3);
        idle(1);
        send(8'h44);
        chk("lit_ack_drop_err", 64'(frame_err), 64'h1);
        for (int i = 0; i < 30 && busy; i++) @(negedge clk);
        chk("lit_ack_idle", 64'(busy), 64'h0);
        ack_delay = 3;
        idle(4);
`endif

        for (int i = 0; i < 300; i++) begin
            send(8'hFF); send(8'h02);
        end
        chk("lit_err_saturate", 64'(err_cnt), 64'hFF);

        ack_rand = 1'b1;
        do_reset();
        for (int f = 0; f < 300; f++) begin
            k = int'($urandom_range(0, 9));
            if (k < 3)      h = 8'hFF;
            else if (k < 8) h = 8'hE0 + 8'($urandom_range(0, 5));
            else            h = 8'($urandom);
            if (h == 8'hFF && $urandom_range(0, 1) == 1) p = 8'h01;
            else                                         p = 8'($urandom);
            send(h);
            if ($urandom_range(0, 14) == 0) g = int'($urandom_range(17, 22));
            else                            g = int'($urandom_range(0, 3));
            idle(g);
            send(p);
            idle(int'($urandom_range(0, 6)));
            if ($urandom_range(0, 59) == 0) do_reset();
        end
        idle(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
